// File: rtl/rx78_loader_pkg.sv
// Shared types and region bounds for the RX-78 cartridge loader.
// Optional padding stage is enabled with RX78_CART_PAD_EN.
package rx78_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_PAD     = 3'd2,
        ST_CLEAR   = 3'd3,
        ST_RELEASE = 3'd4
    } ld_state_e;

    typedef enum logic [1:0] {
        RG_CART1 = 2'd0,
        RG_CART2 = 2'd1,
        RG_EXT   = 2'd2,
        RG_NONE  = 2'd3
    } ld_region_e;

    localparam logic [15:0] CART1_END  = 16'h2000;
    localparam logic [15:0] CART2_END  = 16'h4000;
    localparam logic [15:0] EXT_END    = 16'hC000;
    localparam int          VRAM_DEPTH = 8192;
    localparam logic [7:0]  PAD_BYTE   = 8'hFF;

    function automatic logic [15:0] max_u16(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rx78_ld_decode.sv
// Image offset decoder: selects cart1, cart2, ext RAM or nothing and
// produces the address local to the selected array.
module rx78_ld_decode
    import rx78_loader_pkg::*;
(
    input  logic [24:0] offset,
    output ld_region_e  region,
    output logic [14:0] local_addr
);

    // Windows are contiguous, so test the upper bounds in ascending order
    always_comb begin
        region     = RG_NONE;
        local_addr = 15'd0;
        if (offset < {9'd0, CART1_END}) begin
            region     = RG_CART1;
            local_addr = {2'b00, offset[12:0]};
        end else if (offset < {9'd0, CART2_END}) begin
            region     = RG_CART2;
            local_addr = {2'b00, offset[12:0]};
        end else if (offset < {9'd0, EXT_END}) begin
            region     = RG_EXT;
            local_addr = offset[14:0] - CART2_END[14:0];
        end else begin
            region     = RG_NONE;
            local_addr = 15'd0;
        end
    end

endmodule

// File: rtl/rx78_cart_loader.sv
// RX-78 cartridge loader: ioctl byte stream to cart/ext write strobes, then
// 0xFF padding (RX78_CART_PAD_EN), VRAM sweep and a Z80 reset hold.
module rx78_cart_loader
    import rx78_loader_pkg::*;
#(
    parameter logic [7:0] CART_INDEX  = 8'd1,
    parameter int         HOLD_CYCLES = 16
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  upload_index,
    input  logic        upload,
    input  logic        upload_wr,
    input  logic [24:0] upload_addr,
    input  logic [7:0]  upload_data,
    output logic        wr_cart1,
    output logic        wr_cart2,
    output logic        wr_ext,
    output logic [14:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        vclr_we,
    output logic [12:0] vclr_addr,
    output logic        cpu_reset,
    output logic        busy,
    output logic [15:0] img_size,
    output logic        overflow
);

    localparam logic [12:0] VCLR_LAST = 13'(VRAM_DEPTH - 1);
    localparam logic [15:0] PAD_LAST  = CART2_END - 16'd1;
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    ld_state_e   state_r, next_state_s;
    logic        upload_d_r;
    logic        idx_match_s, rise_s, fall_s, load_wr_s, pad_wr_s;
    logic [15:0] pad_addr_r, pad_addr_nx_s;
    logic [15:0] hold_cnt_r, hold_cnt_nx_s;
    logic [12:0] vclr_addr_r, vclr_addr_nx_s;
    logic        vclr_we_r, cpu_reset_r, busy_r;

    logic [24:0] dec_offset_s;
    ld_region_e  dec_region_s;
    logic [14:0] dec_local_s;
    logic [15:0] off_p1_s;

    logic        wr_cart1_r, wr_cart2_r, wr_ext_r;
    logic        wr_cart1_s, wr_cart2_s, wr_ext_s;
    logic [14:0] wr_addr_r, wr_addr_s;
    logic [7:0]  wr_data_r, wr_data_s;
    logic [15:0] img_size_r, img_size_s;
    logic        overflow_r, overflow_s;

    assign idx_match_s = (upload_index == CART_INDEX);
    assign rise_s      = upload & ~upload_d_r & idx_match_s;
    assign fall_s      = ~upload & upload_d_r & (state_r == ST_LOAD);
    // The byte that arrives together with the rising edge is the first image byte
    assign load_wr_s   = upload & upload_wr & idx_match_s & ((state_r == ST_LOAD) | rise_s);
    assign dec_offset_s = pad_wr_s ? {9'd0, pad_addr_r} : upload_addr;
    assign off_p1_s     = upload_addr[15:0] + 16'd1;

    rx78_ld_decode u_decode (
        .offset     (dec_offset_s),
        .region     (dec_region_s),
        .local_addr (dec_local_s)
    );

    // Sequencer next state; a new cart upload preempts every other state
    always_comb begin
        next_state_s   = state_r;
        pad_addr_nx_s  = pad_addr_r;
        hold_cnt_nx_s  = hold_cnt_r;
        vclr_addr_nx_s = vclr_addr_r;
        pad_wr_s       = 1'b0;
        if (rise_s) begin
            next_state_s = ST_LOAD;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    next_state_s = ST_IDLE;
                end
                ST_LOAD: begin
                    if (fall_s) begin
`ifdef RX78_CART_PAD_EN
                        if (img_size_r >= CART2_END) begin
                            next_state_s   = ST_CLEAR;
                            vclr_addr_nx_s = 13'd0;
                        end else begin
                            next_state_s  = ST_PAD;
                            pad_addr_nx_s = img_size_r;
                        end
`else
                        next_state_s   = ST_CLEAR;
                        vclr_addr_nx_s = 13'd0;
`endif
                    end else begin
                        next_state_s = ST_LOAD;
                    end
                end
                ST_PAD: begin
`ifdef RX78_CART_PAD_EN
                    pad_wr_s = 1'b1;
                    if (pad_addr_r == PAD_LAST) begin
                        next_state_s   = ST_CLEAR;
                        vclr_addr_nx_s = 13'd0;
                    end else begin
                        pad_addr_nx_s = pad_addr_r + 16'd1;
                    end
`else
                    next_state_s   = ST_CLEAR;
                    vclr_addr_nx_s = 13'd0;
`endif
                end
                ST_CLEAR: begin
                    if (vclr_addr_r == VCLR_LAST) begin
                        next_state_s  = ST_RELEASE;
                        hold_cnt_nx_s = 16'd0;
                    end else begin
                        vclr_addr_nx_s = vclr_addr_r + 13'd1;
                    end
                end
                ST_RELEASE: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        hold_cnt_nx_s = hold_cnt_r + 16'd1;
                    end
                end
                default: begin
                    next_state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Sequencer registers; status outputs are aligned with the state they describe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_RELEASE;
            upload_d_r  <= 1'b0;
            pad_addr_r  <= 16'd0;
            hold_cnt_r  <= 16'd0;
            vclr_addr_r <= 13'd0;
            vclr_we_r   <= 1'b0;
            cpu_reset_r <= 1'b1;
            busy_r      <= 1'b1;
        end else begin
            state_r     <= next_state_s;
            upload_d_r  <= upload;
            pad_addr_r  <= pad_addr_nx_s;
            hold_cnt_r  <= hold_cnt_nx_s;
            vclr_addr_r <= vclr_addr_nx_s;
            vclr_we_r   <= (next_state_s == ST_CLEAR);
            cpu_reset_r <= (next_state_s != ST_IDLE);
            busy_r      <= (next_state_s != ST_IDLE);
        end
    end

    // Write datapath: load bytes and pad bytes share the decoder
    always_comb begin
        wr_cart1_s = 1'b0;
        wr_cart2_s = 1'b0;
        wr_ext_s   = 1'b0;
        wr_addr_s  = wr_addr_r;
        wr_data_s  = wr_data_r;
        img_size_s = rise_s ? 16'd0 : img_size_r;
        overflow_s = rise_s ? 1'b0 : overflow_r;
        if (load_wr_s) begin
            case (dec_region_s)
                RG_CART1: wr_cart1_s = 1'b1;
                RG_CART2: wr_cart2_s = 1'b1;
                RG_EXT:   wr_ext_s   = 1'b1;
                default:  overflow_s = 1'b1;
            endcase
            if (dec_region_s != RG_NONE) begin
                wr_addr_s  = dec_local_s;
                wr_data_s  = upload_data;
                img_size_s = max_u16(img_size_s, off_p1_s);
            end else begin
                wr_addr_s = wr_addr_r;
            end
        end else if (pad_wr_s) begin
            case (dec_region_s)
                RG_CART1: wr_cart1_s = 1'b1;
                RG_CART2: wr_cart2_s = 1'b1;
                default:  wr_ext_s   = 1'b0;
            endcase
            wr_addr_s = dec_local_s;
            wr_data_s = PAD_BYTE;
        end else begin
            wr_addr_s = wr_addr_r;
        end
    end

    // Registered write port and image status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cart1_r <= 1'b0;
            wr_cart2_r <= 1'b0;
            wr_ext_r   <= 1'b0;
            wr_addr_r  <= 15'd0;
            wr_data_r  <= 8'd0;
            img_size_r <= 16'd0;
            overflow_r <= 1'b0;
        end else begin
            wr_cart1_r <= wr_cart1_s;
            wr_cart2_r <= wr_cart2_s;
            wr_ext_r   <= wr_ext_s;
            wr_addr_r  <= wr_addr_s;
            wr_data_r  <= wr_data_s;
            img_size_r <= img_size_s;
            overflow_r <= overflow_s;
        end
    end

    assign wr_cart1  = wr_cart1_r;
    assign wr_cart2  = wr_cart2_r;
    assign wr_ext    = wr_ext_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign vclr_we   = vclr_we_r;
    assign vclr_addr = vclr_addr_r;
    assign cpu_reset = cpu_reset_r;
    assign busy      = busy_r;
    assign img_size  = img_size_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_rx78_cart_loader.sv
// Scoreboard bench for rx78_cart_loader; pad expectations follow RX78_CART_PAD_EN.
`timescale 1ns/1ps
module tb_rx78_cart_loader;

    localparam int         HOLD = 16;
    localparam logic [7:0] CART = 8'd1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  upload_index = 8'd0;
    logic        upload = 1'b0;
    logic        upload_wr = 1'b0;
    logic [24:0] upload_addr = 25'd0;
    logic [7:0]  upload_data = 8'd0;
    logic        wr_cart1, wr_cart2, wr_ext, vclr_we, cpu_reset, busy, overflow;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic [12:0] vclr_addr;
    logic [15:0] img_size;

    rx78_cart_loader #(.CART_INDEX(CART), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset(reset), .upload_index(upload_index), .upload(upload),
        .upload_wr(upload_wr), .upload_addr(upload_addr), .upload_data(upload_data),
        .wr_cart1(wr_cart1), .wr_cart2(wr_cart2), .wr_ext(wr_ext), .wr_addr(wr_addr),
        .wr_data(wr_data), .vclr_we(vclr_we), .vclr_addr(vclr_addr), .cpu_reset(cpu_reset),
        .busy(busy), .img_size(img_size), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // expected write = {kind(1 cart1, 2 cart2, 3 ext), local address, data}
    logic [24:0] wr_q[$];
    logic [12:0] vclr_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  m_img_size = 0;
    bit  m_overflow = 1'b0;
    int  exp_pad_n = 0;
    bit  fall_armed = 1'b0;
    int  fall_cnt = 0;
    bit  rel_armed = 1'b0;
    int  rel_cnt = 0;
    bit  expect_idle = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got 0x%0h expected no output at %0t", name, act, $time);
    endtask

    function automatic logic [24:0] exp_write(input int off, input logic [7:0] d);
        logic [1:0] k;
        int la;
        if (off < 'h2000) begin k = 2'd1; la = off; end
        else if (off < 'h4000) begin k = 2'd2; la = off - 'h2000; end
        else begin k = 2'd3; la = off - 'h4000; end
        return {k, la[14:0], d};
    endfunction

    task automatic model_byte(input logic [24:0] off, input logic [7:0] d);
        int o;
        o = int'(off);
        if (o < 'hC000) begin
            wr_q.push_back(exp_write(o, d));
            if (o + 1 > m_img_size) m_img_size = o + 1;
        end else begin
            m_overflow = 1'b1;
        end
    endtask

    task automatic gap(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [24:0] off, input logic [7:0] d);
        upload_addr = off;
        upload_data = d;
        upload_wr   = 1'b1;
        if (upload && upload_index == CART) model_byte(off, d);
        @(posedge clk); #1;
        upload_wr = 1'b0;
    endtask

    task automatic start_load();
        expect_idle  = 1'b0;
        rel_armed    = 1'b0;
        upload_index = CART;
        upload       = 1'b1;
        m_img_size   = 0;
        m_overflow   = 1'b0;
    endtask

    task automatic end_load();
        int pad_n;
        pad_n     = 0;
        upload    = 1'b0;
        upload_wr = 1'b0;
`ifdef RX78_CART_PAD_EN
        for (int a = m_img_size; a < 'h4000; a++) begin
            wr_q.push_back(exp_write(a, 8'hFF));
            pad_n++;
        end
`endif
        for (int a = 0; a < 8192; a++) vclr_q.push_back(13'(a));
        exp_pad_n  = pad_n;
        fall_cnt   = 0;
        fall_armed = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 40000) begin @(negedge clk); n++; end
        check({name, "_done"}, 32'(busy), 32'd0);
        check({name, "_img_size"}, 32'(img_size), 32'(m_img_size));
        check({name, "_overflow"}, 32'(overflow), 32'(m_overflow));
        check({name, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
        check({name, "_wr_left"}, 32'(wr_q.size()), 32'd0);
        check({name, "_vclr_left"}, 32'(vclr_q.size()), 32'd0);
        expect_idle = 1'b1;
        repeat (4) @(negedge clk);
        expect_idle = 1'b0;
        @(posedge clk); #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe
    initial begin
        logic [24:0] exp_w;
        logic [12:0] exp_v;
        logic [1:0]  k;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (wr_cart1 || wr_cart2 || wr_ext) begin
                    k = wr_ext ? 2'd3 : (wr_cart2 ? 2'd2 : 2'd1);
                    check("wr_onehot", 32'($countones({wr_ext, wr_cart2, wr_cart1})), 32'd1);
                    if (wr_q.size() == 0) begin
                        unexpected("wr_unexpected", 32'({k, wr_addr, wr_data}));
                    end else begin
                        exp_w = wr_q.pop_front();
                        check("wr", 32'({k, wr_addr, wr_data}), 32'(exp_w));
                    end
                end
                if (vclr_we) begin
                    if (fall_armed) begin
                        check("pad_duration", 32'(fall_cnt), 32'(1 + exp_pad_n));
                        fall_armed = 1'b0;
                    end
                    if (vclr_q.size() == 0) begin
                        unexpected("vclr_unexpected", 32'(vclr_addr));
                    end else begin
                        exp_v = vclr_q.pop_front();
                        check("vclr_addr", 32'(vclr_addr), 32'(exp_v));
                        if (exp_v == 13'h1FFF) begin rel_armed = 1'b1; rel_cnt = 0; end
                    end
                end else if (fall_armed) begin
                    fall_cnt++;
                end
                if (rel_armed && !vclr_we) begin
                    if (cpu_reset) rel_cnt++;
                    else begin
                        check("release_len", 32'(rel_cnt), 32'(HOLD));
                        rel_armed = 1'b0;
                    end
                end
                if (expect_idle) begin
                    check("idle_busy", 32'(busy), 32'd0);
                    check("idle_cpu_reset", 32'(cpu_reset), 32'd0);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // power-on values, then the reset stretch
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_strobes", 32'({wr_cart1, wr_cart2, wr_ext, vclr_we}), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_vclr_addr", 32'(vclr_addr), 32'd0);
        check("rst_img_size", 32'(img_size), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        rel_cnt = 0;
        rel_armed = 1'b1;
        wait_done("poweron");

        // non-cart download never leaves IDLE
        expect_idle  = 1'b1;
        upload_index = 8'd2;
        upload       = 1'b1;
        for (int i = 0; i < 6; i++) send_byte(25'($urandom_range(0, 'h3FFF)), 8'($urandom));
        gap(2);
        upload = 1'b0;
        gap(3);
        check("idx2_img_size", 32'(img_size), 32'(m_img_size));
        expect_idle = 1'b0;

        // sequential 8K image, first byte on the rising edge, back to back
        start_load();
        for (int a = 0; a < 'h2000; a++) send_byte(25'(a), 8'(a));
        end_load();
        wait_done("seq8k");

        // sparse 48K image with random gaps
        start_load();
        gap(1);
        send_byte(25'h004000, 8'($urandom));
        for (int i = 0; i < 24; i++) begin
            send_byte(25'($urandom_range(0, 'hBFFF)), 8'($urandom));
            gap($urandom_range(0, 2));
        end
        send_byte(25'h00BFFF, 8'($urandom));
        end_load();
        wait_done("img48k");

        // out-of-range offsets mixed with a near-full cart2 image
        start_load();
        send_byte(25'h00C000, 8'h5A);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_img_size", 32'(img_size), 32'd0);
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) send_byte(25'($urandom_range('hC000, 'h1FFFFFF)), 8'($urandom));
            else send_byte(25'($urandom_range('h3000, 'h3FFF)), 8'($urandom));
            gap($urandom_range(0, 1));
        end
        end_load();
        wait_done("ovf");

        // new cart upload while CLEAR is at 0x0800
        start_load();
        gap(1);
        send_byte(25'h003FFE, 8'h11);
        send_byte(25'h003FFF, 8'h22);
        gap(1);
        end_load();
        n = 0;
        while (vclr_q.size() > 8192 - 'h801 && n < 20000) begin @(posedge clk); n++; end
        check("abort_reached", 32'(vclr_q.size()), 32'(8192 - 'h801));
        #1;
        start_load();
        while (vclr_q.size() > 1) void'(vclr_q.pop_back());
        @(posedge clk);
        @(negedge clk);
        check("abort_img_size", 32'(img_size), 32'd0);
        check("abort_vclr_we", 32'(vclr_we), 32'd0);
        check("abort_cpu_reset", 32'(cpu_reset), 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) send_byte(25'($urandom_range(0, 'hBFFF)), 8'($urandom));
        end_load();
        wait_done("abort");

        // reset in the middle of a load
        start_load();
        gap(1);
        for (int i = 0; i < 4; i++) send_byte(25'($urandom_range(0, 'h3FFF)), 8'($urandom));
        reset = 1'b1;
        #1;
        check("midrst_strobes", 32'({wr_cart1, wr_cart2, wr_ext, vclr_we}), 32'd0);
        check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("midrst_img_size", 32'(img_size), 32'd0);
        wr_q.delete();
        vclr_q.delete();
        fall_armed = 1'b0;
        upload     = 1'b0;
        m_img_size = 0;
        m_overflow = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        rel_cnt = 0;
        rel_armed = 1'b1;
        wait_done("midrst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
